// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame bit levels and
// elaboration-time helpers for the oversampling divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

  function automatic int uart_divisor(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

  function automatic int uart_cnt_width(input int divisor);
    return (divisor > 1) ? $clog2(divisor) : 1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-consumer bundle: one-entry valid/ready word buffer plus
// line status flags.
interface uart_receiver_if #(
  parameter int FRAME_DATA_LENGTH = 8
);
  logic [0:FRAME_DATA_LENGTH-1] data;
  logic                         valid;
  logic                         ready;
  logic                         busy;
  logic                         frame_error;
  logic                         overrun;

  modport master (output data, valid, busy, frame_error, overrun, input ready);
  modport slave  (input data, valid, busy, frame_error, overrun, output ready);
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: a registered one-clock tick every DIVISOR
// clocks, with a synchronous restart that realigns the phase to zero.
module uart_rx_tick_gen #(
  parameter int DIVISOR = 10,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divisor counter; tick is registered so it is glitch-free for the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      tick  <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizer, oversampled majority vote, frame FSM and a
// one-entry holding buffer presented through uart_receiver_if.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int NATIVE_CLK_FREQUENCY = 1_000_000_000,
  parameter int BAUDRATE             = 9600,
  parameter int FRAME_DATA_LENGTH    = 8,
  parameter bit ENABLE_BIG_ENDIAN    = 1'b1,
  parameter int OVERSAMPLE           = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  uart_receiver_if.master bus
);
  localparam int DIVISOR = uart_divisor(NATIVE_CLK_FREQUENCY, BAUDRATE, OVERSAMPLE);
  localparam int CNT_W   = uart_cnt_width(DIVISOR);
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(FRAME_DATA_LENGTH);
  localparam logic [OS_W-1:0]  T_FIRST  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  T_MID    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  T_DECIDE = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  T_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] B_LAST   = BIT_W'(FRAME_DATA_LENGTH - 1);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_receiver: clock too slow for BAUDRATE*OVERSAMPLE (DIVISOR < 2)");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
    $error("uart_receiver: OVERSAMPLE must be even and >= 8");
  end
  if (FRAME_DATA_LENGTH < 5 || FRAME_DATA_LENGTH > 9) begin : g_bad_length
    $error("uart_receiver: FRAME_DATA_LENGTH must be 5..9");
  end

  logic                         rx_meta_r, rx_sync_r, rx_prev_r;
  uart_rx_state_t               state_r, state_s;
  logic                         tick_s, restart_s, fall_s, decide_s, bit_end_s;
  logic                         vote_s, commit_s, ferr_s;
  logic [OS_W-1:0]              os_cnt_r;
  logic [BIT_W-1:0]             bit_cnt_r, slot_s;
  logic                         samp_a_r, samp_b_r;
  logic [0:FRAME_DATA_LENGTH-1] shift_r;

  uart_rx_tick_gen #(.DIVISOR(DIVISOR), .CNT_W(CNT_W)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart_s),
    .tick    (tick_s)
  );

  assign fall_s    = rx_prev_r & ~rx_sync_r;
  assign decide_s  = tick_s && (os_cnt_r == T_DECIDE);
  assign bit_end_s = tick_s && (os_cnt_r == T_LAST);
  // Third vote is the live sample taken at the decision tick itself
  assign vote_s    = majority3(samp_a_r, samp_b_r, rx_sync_r);
  assign slot_s    = ENABLE_BIG_ENDIAN ? bit_cnt_r : (B_LAST - bit_cnt_r);

  // Two-flop synchronizer plus edge-detect history, idling at line-high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= IDLE_BIT;
      rx_sync_r <= IDLE_BIT;
      rx_prev_r <= IDLE_BIT;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and frame actions; a good stop bit returns to IDLE mid-bit
  always_comb begin
    state_s   = state_r;
    restart_s = 1'b0;
    commit_s  = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_s   = START;
          restart_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (decide_s && (vote_s != START_BIT)) begin
          state_s = IDLE;
        end else if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_cnt_r == B_LAST)) begin
          state_s = STOP;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (decide_s) begin
          if (vote_s == STOP_BIT) begin
            commit_s = 1'b1;
            state_s  = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = WAIT_IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      WAIT_IDLE: begin
        if (rx_sync_r == IDLE_BIT) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Oversample/bit counters, vote samples and the data shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt_r  <= '0;
      bit_cnt_r <= '0;
      samp_a_r  <= 1'b0;
      samp_b_r  <= 1'b0;
      shift_r   <= '0;
    end else begin
      if (restart_s) begin
        os_cnt_r  <= '0;
        bit_cnt_r <= '0;
      end else if (tick_s && (state_r != IDLE)) begin
        os_cnt_r <= (os_cnt_r == T_LAST) ? '0 : os_cnt_r + OS_W'(1);
        if ((state_r == DATA) && bit_end_s) begin
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end
      end
      if (tick_s && (os_cnt_r == T_FIRST)) begin
        samp_a_r <= rx_sync_r;
      end
      if (tick_s && (os_cnt_r == T_MID)) begin
        samp_b_r <= rx_sync_r;
      end
      if ((state_r == DATA) && decide_s) begin
        shift_r[slot_s] <= vote_s;
      end
    end
  end

  // Holding buffer and status outputs; a pop in the commit cycle frees the slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data        <= '0;
      bus.valid       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.busy        <= (state_s != IDLE);
      bus.frame_error <= ferr_s;
      bus.overrun     <= commit_s && bus.valid && !bus.ready;
      if (commit_s && (!bus.valid || bus.ready)) begin
        bus.data  <= shift_r;
        bus.valid <= 1'b1;
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end
endmodule
